g4_table_arb_ctrl: RTL and testbench

Arbiter and update sequencer for one single-port G4 rule table (171-bit entries, 1-cycle registered read). It shares the table port between the packet-lookup pipeline and the rule-update engine. Lookups get priority, with a starvation bound for updates. Insert and delete run as checked read-check-write sequences; modify is a blind write. One instance sits in front of each G4 table instance, per subset and per table.

---
 rtl/g4_pkg.sv | 30 +++
 rtl/g4_sat_cnt.sv | 17 +
 rtl/g4_table_arb_ctrl.sv | 164 ++++++++++++++++
 tb/tb_g4_table_arb_ctrl.sv | 379 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/g4_pkg.sv
// Shared definitions for the G4 rule-table access path: widths, entry field
// positions, update op encodings and the arbiter state type.
package g4_pkg;

    localparam int ADDR_W  = 11;
    localparam int ENTRY_W = 171;

    localparam int RID_W   = 11;
    localparam int RID_LSB = 11;
    localparam int RID_MSB = 21;
    localparam int IDX_LSB = 0;
    localparam int IDX_MSB = 10;
    localparam int WC_BIT  = 22;

    localparam logic [RID_W-1:0] EMPTY_ID = 11'h7FF;

    localparam logic [1:0] OP_INS = 2'd0;
    localparam logic [1:0] OP_DEL = 2'd1;
    localparam logic [1:0] OP_MOD = 2'd2;
    localparam logic [1:0] OP_RSV = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD,
        ST_CHK,
        ST_WR,
        ST_DONE
    } arb_state_t;

endpackage

// File: rtl/g4_sat_cnt.sv
// 16-bit event counter that sticks at all-ones instead of wrapping.
module g4_sat_cnt (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        inc,
    output logic [15:0] cnt
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (inc && (cnt != 16'hFFFF)) begin
            cnt <= cnt + 16'd1;
        end
    end

endmodule

// File: rtl/g4_table_arb_ctrl.sv
// Port arbiter and insert/delete/modify sequencer for one single-port G4 rule table.
// Optional statistics counters are built when G4_ARB_STATS_EN is defined.
module g4_table_arb_ctrl #(
    parameter int               ADDR_W       = g4_pkg::ADDR_W,
    parameter int               ENTRY_W      = g4_pkg::ENTRY_W,
    parameter logic [10:0]      EMPTY_ID     = g4_pkg::EMPTY_ID,
    parameter int               STARVE_LIMIT = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               lk_req,
    input  logic [ADDR_W-1:0]  lk_addr,
    output logic               lk_gnt,
    output logic               lk_valid,
    output logic [ENTRY_W-1:0] lk_data,
    input  logic               up_valid,
    input  logic [1:0]         up_op,
    input  logic [ADDR_W-1:0]  up_addr,
    input  logic [ENTRY_W-1:0] up_entry,
    output logic               up_ready,
    output logic               up_done,
    output logic               up_err,
    output logic               tbl_we,
    output logic [ADDR_W-1:0]  tbl_addr,
    output logic [ENTRY_W-1:0] tbl_din,
    input  logic [ENTRY_W-1:0] tbl_dout,
    output logic [15:0]        stat_ins,
    output logic [15:0]        stat_del,
    output logic [15:0]        stat_err
);
    import g4_pkg::*;

    localparam int               SC_W   = $clog2(STARVE_LIMIT + 1);
    localparam logic [SC_W-1:0]  SC_MAX = SC_W'(STARVE_LIMIT);

    arb_state_t          state;
    logic [1:0]          op_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [ENTRY_W-1:0]  entry_q;
    logic [SC_W-1:0]     starve_cnt;

    logic                idle;
    logic                accept;
    logic                chk_ok;
    logic [RID_W-1:0]    stored_rid;
    logic [ENTRY_W-1:0]  del_entry;

    // Gating with rst_n keeps grants and the table port quiet while reset is held.
    assign idle     = rst_n && (state == ST_IDLE);
    assign accept   = idle && up_valid && (!lk_req || (starve_cnt == SC_MAX));
    assign up_ready = accept;
    assign lk_gnt   = idle && lk_req && !accept;
    assign lk_data  = tbl_dout;

    assign stored_rid = tbl_dout[RID_MSB:RID_LSB];
    assign chk_ok     = (op_q == OP_INS) ? (stored_rid == EMPTY_ID)
                                         : (stored_rid == entry_q[RID_MSB:RID_LSB]);

    always_comb begin
        del_entry                  = '0;
        del_entry[RID_MSB:RID_LSB] = EMPTY_ID;
        tbl_we   = 1'b0;
        tbl_addr = '0;
        tbl_din  = '0;
        case (state)
            ST_IDLE: if (lk_gnt) tbl_addr = lk_addr;
            ST_RD:   tbl_addr = addr_q;
            ST_WR: begin
                tbl_we   = 1'b1;
                tbl_addr = addr_q;
                tbl_din  = (op_q == OP_DEL) ? del_entry : entry_q;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            op_q       <= OP_INS;
            addr_q     <= '0;
            entry_q    <= '0;
            starve_cnt <= '0;
            lk_valid   <= 1'b0;
            up_done    <= 1'b0;
            up_err     <= 1'b0;
        end else begin
            lk_valid <= lk_gnt;
            up_done  <= 1'b0;
            up_err   <= 1'b0;

            if (!up_valid || accept) begin
                starve_cnt <= '0;
            end else if ((state == ST_IDLE) && (starve_cnt != SC_MAX)) begin
                starve_cnt <= starve_cnt + 1'b1;
            end

            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        op_q    <= up_op;
                        addr_q  <= up_addr;
                        entry_q <= up_entry;
                        case (up_op)
                            OP_INS, OP_DEL: state <= ST_RD;
                            OP_MOD:         state <= ST_WR;
                            default: begin
                                state   <= ST_DONE;
                                up_done <= 1'b1;
                                up_err  <= 1'b1;
                            end
                        endcase
                    end
                end
                ST_RD: state <= ST_CHK;
                ST_CHK: begin
                    if (chk_ok) begin
                        state <= ST_WR;
                    end else begin
                        state   <= ST_DONE;
                        up_done <= 1'b1;
                        up_err  <= 1'b1;
                    end
                end
                ST_WR: begin
                    state   <= ST_DONE;
                    up_done <= 1'b1;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef G4_ARB_STATS_EN
    logic ok_done;
    assign ok_done = up_done && !up_err;

    g4_sat_cnt u_cnt_ins (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (ok_done && (op_q == OP_INS)),
        .cnt   (stat_ins)
    );

    g4_sat_cnt u_cnt_del (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (ok_done && (op_q == OP_DEL)),
        .cnt   (stat_del)
    );

    g4_sat_cnt u_cnt_err (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (up_done && up_err),
        .cnt   (stat_err)
    );
`else
    assign stat_ins = '0;
    assign stat_del = '0;
    assign stat_err = '0;
`endif

endmodule

// File: tb/tb_g4_table_arb_ctrl.sv
// Randomized bench for g4_table_arb_ctrl against a transaction-level table model.
module tb_g4_table_arb_ctrl;
    import g4_pkg::*;

    localparam int AW  = 11;
    localparam int EW  = 171;
    localparam int LIM = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          lk_req;
    logic [AW-1:0] lk_addr;
    logic          lk_gnt;
    logic          lk_valid;
    logic [EW-1:0] lk_data;
    logic          up_valid;
    logic [1:0]    up_op;
    logic [AW-1:0] up_addr;
    logic [EW-1:0] up_entry;
    logic          up_ready;
    logic          up_done;
    logic          up_err;
    logic          tbl_we;
    logic [AW-1:0] tbl_addr;
    logic [EW-1:0] tbl_din;
    logic [EW-1:0] tbl_dout;
    logic [15:0]   stat_ins;
    logic [15:0]   stat_del;
    logic [15:0]   stat_err;

    g4_table_arb_ctrl #(
        .ADDR_W       (AW),
        .ENTRY_W      (EW),
        .EMPTY_ID     (11'h7FF),
        .STARVE_LIMIT (LIM)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .lk_req   (lk_req),
        .lk_addr  (lk_addr),
        .lk_gnt   (lk_gnt),
        .lk_valid (lk_valid),
        .lk_data  (lk_data),
        .up_valid (up_valid),
        .up_op    (up_op),
        .up_addr  (up_addr),
        .up_entry (up_entry),
        .up_ready (up_ready),
        .up_done  (up_done),
        .up_err   (up_err),
        .tbl_we   (tbl_we),
        .tbl_addr (tbl_addr),
        .tbl_din  (tbl_din),
        .tbl_dout (tbl_dout),
        .stat_ins (stat_ins),
        .stat_del (stat_del),
        .stat_err (stat_err)
    );

    always #5 clk = ~clk;

    // Single-port table with registered read; preloaded through the init port.
    logic          init_we;
    logic [3:0]    init_addr;
    logic [EW-1:0] init_data;
    logic [EW-1:0] tbl_mem [0:15];

    always @(posedge clk) begin
        if (init_we) tbl_mem[init_addr] <= init_data;
        else if (tbl_we) tbl_mem[tbl_addr[3:0]] <= tbl_din;
        tbl_dout <= tbl_mem[tbl_addr[3:0]];
    end

    // Reference model state
    logic [EW-1:0] ref_mem [0:15];
    int            m_ins, m_del, m_err;
    logic          pg;
    logic [3:0]    pa;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [191:0] obs, input logic [191:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [EW-1:0] mk_entry(input logic [10:0] rid);
        logic [191:0] r;
        r = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        r[21:11] = rid;
        return r[EW-1:0];
    endfunction

    task automatic cyc();
        @(posedge clk);
        #2;
        chk("lk_valid", {191'd0, lk_valid}, {191'd0, pg});
        if (pg) chk("lk_data", {21'd0, lk_data}, {21'd0, ref_mem[pa]});
    endtask

    task automatic check_stats();
`ifdef G4_ARB_STATS_EN
        chk("stat_ins", stat_ins, m_ins[15:0]);
        chk("stat_del", stat_del, m_del[15:0]);
        chk("stat_err", stat_err, m_err[15:0]);
`else
        chk("stat_ins", stat_ins, 0);
        chk("stat_del", stat_del, 0);
        chk("stat_err", stat_err, 0);
`endif
    endtask

    task automatic do_lookup(input logic [3:0] a);
        cyc();
        lk_req  = 1'b1;
        lk_addr = {7'd0, a};
        #1;
        chk("lk_gnt", lk_gnt, 1);
        pg = 1'b1;
        pa = a;
        cyc();
        lk_req = 1'b0;
        #1;
        pg = 1'b0;
    endtask

    task automatic do_update(input logic [1:0] op, input logic [3:0] a,
                             input logic [EW-1:0] e, input bit hold);
        int            waits;
        int            lat;
        bit            exp_err;
        bit            exp_wr;
        bit            saw_wr;
        logic [10:0]   rid_st;
        logic [EW-1:0] exp_din;

        cyc();
        up_valid = 1'b1;
        up_op    = op;
        up_addr  = {7'd0, a};
        up_entry = e;
        lk_req   = hold;
        lk_addr  = 11'($urandom_range(0, 15));
        waits    = 0;
        #1;
        while (!up_ready && waits < 20) begin
            chk("lk_gnt_starve", lk_gnt, hold);
            pg = hold;
            pa = lk_addr[3:0];
            cyc();
            lk_addr = 11'($urandom_range(0, 15));
            waits++;
            #1;
        end
        chk("accept_wait", waits, hold ? LIM : 0);
        chk("up_ready", up_ready, 1);
        chk("lk_gnt_accept", lk_gnt, 0);
        pg = 1'b0;

        rid_st  = ref_mem[a][21:11];
        exp_err = 1'b0;
        exp_din = e;
        case (op)
            OP_INS: begin
                exp_err = (rid_st != 11'h7FF);
                lat     = exp_err ? 3 : 4;
            end
            OP_DEL: begin
                exp_err        = (rid_st != e[21:11]);
                lat            = exp_err ? 3 : 4;
                exp_din        = '0;
                exp_din[21:11] = 11'h7FF;
            end
            OP_MOD:  lat = 2;
            default: begin
                exp_err = 1'b1;
                lat     = 1;
            end
        endcase
        exp_wr = !exp_err;
        saw_wr = 1'b0;

        for (int c = 1; c <= lat + 1; c++) begin
            cyc();
            up_valid = 1'b0;
            lk_addr  = 11'($urandom_range(0, 15));
            #1;
            if (tbl_we) begin
                saw_wr = 1'b1;
                chk("wr_addr", tbl_addr, {7'd0, a});
                chk("wr_din", {21'd0, tbl_din}, {21'd0, exp_din});
            end
            if (c <= lat) begin
                chk("lk_gnt_busy", lk_gnt, 0);
                pg = 1'b0;
                chk("up_done_time", up_done, (c == lat) ? 1 : 0);
                if (c == lat) begin
                    chk("up_err", up_err, exp_err);
                    if (exp_wr) ref_mem[a] = exp_din;
                    if (!exp_err && op == OP_INS) m_ins++;
                    if (!exp_err && op == OP_DEL) m_del++;
                    if (exp_err) m_err++;
                end
            end else begin
                chk("lk_gnt_resume", lk_gnt, hold);
                chk("up_done_after", up_done, 0);
                pg = hold;
                pa = lk_addr[3:0];
            end
        end
        chk("write_seen", saw_wr, exp_wr);
    endtask

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish, checks %0d", n_chk);
        $fatal(1);
    end

    initial begin
        logic [EW-1:0] e;
        int            r;
        logic [3:0]    a;
        logic [1:0]    op;

        rst_n     = 1'b0;
        lk_req    = 1'b0;
        lk_addr   = '0;
        up_valid  = 1'b0;
        up_op     = 2'd0;
        up_addr   = '0;
        up_entry  = '0;
        init_we   = 1'b0;
        init_addr = '0;
        init_data = '0;
        pg        = 1'b0;
        pa        = '0;
        m_ins     = 0;
        m_del     = 0;
        m_err     = 0;

        repeat (2) @(posedge clk);
        #2;
        lk_req   = 1'b1;
        up_valid = 1'b1;
        lk_addr  = 11'd3;
        up_addr  = 11'd6;
        #1;
        chk("rst_lk_gnt", lk_gnt, 0);
        chk("rst_up_ready", up_ready, 0);
        chk("rst_tbl_we", tbl_we, 0);
        chk("rst_tbl_addr", tbl_addr, 0);
        chk("rst_lk_valid", lk_valid, 0);
        chk("rst_up_done", up_done, 0);
        chk("rst_up_err", up_err, 0);
        check_stats();
        lk_req   = 1'b0;
        up_valid = 1'b0;

        for (int i = 0; i < 16; i++) begin
            ref_mem[i] = mk_entry((i % 3 == 0 || i == 5) ? 11'h7FF : 11'(i));
            @(posedge clk);
            #2;
            init_we   = 1'b1;
            init_addr = 4'(i);
            init_data = ref_mem[i];
        end
        @(posedge clk);
        #2;
        init_we = 1'b0;
        rst_n   = 1'b1;

        // Lookup stream over addresses 0..3
        cyc();
        for (int i = 0; i < 4; i++) begin
            if (i > 0) cyc();
            lk_req  = 1'b1;
            lk_addr = 11'(i);
            #1;
            chk("stream_gnt", lk_gnt, 1);
            pg = 1'b1;
            pa = 4'(i);
        end
        cyc();
        lk_req = 1'b0;
        #1;
        pg = 1'b0;

        // Insert into empty slot, then delete mismatch and match
        do_update(OP_INS, 4'd5, mk_entry(11'h012), 1'b0);
        do_lookup(4'd5);
        chk("rid5_ins", lk_data[21:11], 11'h012);
        do_update(OP_DEL, 4'd5, mk_entry(11'h013), 1'b0);
        do_update(OP_DEL, 4'd5, mk_entry(11'h012), 1'b0);
        do_lookup(4'd5);
        chk("rid5_del", lk_data[21:11], 11'h7FF);

        // Starvation: modify while lookups are held
        do_update(OP_MOD, 4'd3, mk_entry(11'h055), 1'b1);
        do_update(2'd3, 4'd7, mk_entry(11'h001), 1'b0);

        // Reset while the insert sits in CHK
        cyc();
        up_valid = 1'b1;
        up_op    = OP_INS;
        up_addr  = 11'd5;
        up_entry = mk_entry(11'h0AA);
        lk_req   = 1'b0;
        #1;
        chk("rstseq_ready", up_ready, 1);
        pg = 1'b0;
        cyc();
        up_valid = 1'b0;
        cyc();
        #1;
        rst_n    = 1'b0;
        lk_req   = 1'b1;
        up_valid = 1'b1;
        m_ins    = 0;
        m_del    = 0;
        m_err    = 0;
        #1;
        chk("mid_lk_gnt", lk_gnt, 0);
        chk("mid_up_ready", up_ready, 0);
        chk("mid_tbl_we", tbl_we, 0);
        chk("mid_tbl_addr", tbl_addr, 0);
        chk("mid_lk_valid", lk_valid, 0);
        chk("mid_up_done", up_done, 0);
        check_stats();
        @(posedge clk);
        @(posedge clk);
        #2;
        chk("mid_hold_we", tbl_we, 0);
        lk_req   = 1'b0;
        up_valid = 1'b0;
        rst_n    = 1'b1;
        pg       = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cyc();
            #1;
            chk("post_rst_done", up_done, 0);
            chk("post_rst_we", tbl_we, 0);
        end
        do_lookup(4'd5);
        chk("rid5_kept", lk_data[21:11], 11'h7FF);

        // Randomized mix of lookups and updates
        for (int t = 0; t < 80; t++) begin
            r = $urandom_range(0, 9);
            a = 4'($urandom_range(0, 15));
            if (r == 9) begin
                for (int k = 0; k < int'($urandom_range(1, 4)); k++) do_lookup(4'($urandom_range(0, 15)));
            end else begin
                if (r <= 2) op = OP_INS;
                else if (r <= 5) op = OP_DEL;
                else if (r <= 7) op = OP_MOD;
                else op = OP_RSV;
                if (op == OP_DEL && $urandom_range(0, 1) == 1) e = mk_entry(ref_mem[a][21:11]);
                else e = mk_entry(11'($urandom_range(0, 15)));
                do_update(op, a, e, $urandom_range(0, 2) == 0);
            end
        end

        cyc();
        lk_req   = 1'b0;
        up_valid = 1'b0;
        #1;
        pg = 1'b0;
        cyc();
        cyc();
        check_stats();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
